dm_arbiter: RTL and testbench

- Two-port round-robin arbiter and access sequencer in front of the DataMemory block.
- Port 0 is the CPU load/store stage. Port 1 is a secondary master (loader/debug/DMA).
- Serialises single-word read and write requests onto the Mem_read/Mem_write/Mem_address/Write_data/Read_Data interface, waits the memory read latency, and returns one response per accepted request.

---
 rtl/dm_arbiter.sv | 138 +++++++++++++
 tb/tb_dm_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter and access sequencer for DataMemory.
//   Port 0 is the CPU load/store stage, port 1 a secondary master.
//   Accepted single-word requests are serialised onto the Mem_* interface,
//   reads wait READ_LAT cycles, and one response is returned per request.
// Ports:
//   clk, reset (sync, active-low)
//   reqN_valid/we/addr/wdata -> reqN_ready   request handshake, N = 0,1
//   rspN_valid, rspN_rdata                   one-cycle response pulse + data
//   Mem_read, Mem_write, Mem_address, Write_data, Read_Data  memory side
//   busy                                     high whenever not IDLE
module dm_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              Mem_read,
  output logic              Mem_write,
  output logic [ADDR_W-1:0] Mem_address,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] Read_Data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(READ_LAT);

  state_t            state;
  logic              rr_last;   // port granted most recently
  logic              port_q;    // port owning the access in flight
  logic              we_q;
  logic [2:0]        cnt;       // Mem_read cycles so far, ISSUE included
  logic              grant0;
  logic              grant1;
  logic              finish;
  logic [DATA_W-1:0] rsp_data;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = rr_last;
        grant1 = !rr_last;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // The access completes on the edge that leaves ISSUE (writes, or reads
  // with single-cycle latency) or on the last WAIT edge of a longer read.
  always_comb begin
    finish   = ((state == ISSUE) && (we_q || (LAT == 3'd1))) ||
               ((state == WAIT) && (cnt == LAT));
    rsp_data = we_q ? '0 : Read_Data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      cnt         <= '0;
      Mem_read    <= 1'b0;
      Mem_write   <= 1'b0;
      Mem_address <= '0;
      Write_data  <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_rdata  <= '0;
      rsp1_rdata  <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (finish) begin
        state       <= RESP;
        Mem_read    <= 1'b0;
        Mem_write   <= 1'b0;
        Mem_address <= '0;
        Write_data  <= '0;
        if (port_q) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= rsp_data;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= rsp_data;
        end
      end else begin
        case (state)
          IDLE: begin
            if (grant0 || grant1) begin
              state       <= ISSUE;
              port_q      <= grant1;
              rr_last     <= grant1;
              we_q        <= grant1 ? req1_we : req0_we;
              Mem_write   <= grant1 ? req1_we : req0_we;
              Mem_read    <= grant1 ? !req1_we : !req0_we;
              Mem_address <= grant1 ? req1_addr : req0_addr;
              Write_data  <= grant1 ? req1_wdata : req0_wdata;
              cnt         <= 3'd1;
            end
          end
          ISSUE: begin
            state <= WAIT;
            cnt   <= 3'd2;
          end
          WAIT:    cnt   <= cnt + 3'd1;
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter.
//   Instance 0 uses READ_LAT=1, instance 1 uses READ_LAT=3; each has its own
//   behavioural memory. A reference model predicts grants, memory traffic and
//   responses; predictions are queued and retired as the DUT responds.
module tb_dm_arbiter;

  logic        clk;
  logic        rst_n [2];
  logic        v0 [2], we0 [2], v1 [2], we1 [2];
  logic [31:0] a0 [2], d0 [2], a1 [2], d1 [2];
  logic        rdy0 [2], rdy1 [2], rv0 [2], rv1 [2];
  logic [31:0] rd0 [2], rd1 [2];
  logic        mr [2], mw [2], bz [2];
  logic [31:0] ma [2], wd [2], rdat [2];

  typedef struct {
    int          inst;
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t        sb [$];
  int          glog [$];
  logic [31:0] shadow [2][64];
  bit          m_rr [2];
  int          acc_c [2], free_c [2], rrun [2], wrun [2];
  bit          post_rst [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [31:0] mem [64];

    dm_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(k == 0 ? 1 : 3)) u_dut (
      .clk        (clk),
      .reset      (rst_n[k]),
      .req0_valid (v0[k]),
      .req0_we    (we0[k]),
      .req0_addr  (a0[k]),
      .req0_wdata (d0[k]),
      .req0_ready (rdy0[k]),
      .rsp0_valid (rv0[k]),
      .rsp0_rdata (rd0[k]),
      .req1_valid (v1[k]),
      .req1_we    (we1[k]),
      .req1_addr  (a1[k]),
      .req1_wdata (d1[k]),
      .req1_ready (rdy1[k]),
      .rsp1_valid (rv1[k]),
      .rsp1_rdata (rd1[k]),
      .Mem_read   (mr[k]),
      .Mem_write  (mw[k]),
      .Mem_address(ma[k]),
      .Write_data (wd[k]),
      .Read_Data  (rdat[k]),
      .busy       (bz[k])
    );

    always @(posedge clk) if (mw[k]) mem[ma[k][7:2]] <= wd[k];
    assign rdat[k] = mem[ma[k][7:2]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int first_idx(input int k);
    foreach (sb[i]) if (sb[i].inst == k) return i;
    return -1;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic mon(input int k);
    int   idx;
    int   lat;
    bit   w;
    exp_t e;
    if (post_rst[k]) begin
      check("rst_mem_read", mr[k], 0);
      check("rst_mem_write", mw[k], 0);
      check("rst_busy", bz[k], 0);
      check("rst_rsp0", rv0[k], 0);
      check("rst_rsp1", rv1[k], 0);
      check("rst_rdata0", rd0[k], 0);
      check("rst_rdata1", rd1[k], 0);
      check("rst_addr", ma[k], 0);
      post_rst[k] = 0;
    end
    if (!rst_n[k]) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].inst == k) sb.delete(i);
      m_rr[k]     = 1'b1;
      acc_c[k]    = cyc + 1;
      free_c[k]   = cyc + 1;
      rrun[k]     = -1000;
      wrun[k]     = -1000;
      post_rst[k] = 1;
      return;
    end
    check("rw_exclusive", mr[k] & mw[k], 0);
    check("busy", bz[k], (cyc > acc_c[k]) && (cyc < free_c[k]));
    idx = first_idx(k);
    if (mr[k] || mw[k]) begin
      if (idx < 0) check("mem_unexpected", 1, 0);
      else begin
        check("mem_addr", ma[k], sb[idx].addr);
        check("mem_dir", mw[k], sb[idx].we);
        if (mw[k]) check("mem_wdata", wd[k], sb[idx].wdata);
      end
    end
    if (mr[k]) rrun[k]++;
    else begin
      if (rrun[k] > 0) check("read_len", rrun[k], lat_of(k));
      rrun[k] = 0;
    end
    if (mw[k]) wrun[k]++;
    else begin
      if (wrun[k] > 0) check("write_len", wrun[k], 1);
      wrun[k] = 0;
    end
    if (rv0[k] || rv1[k]) begin
      check("rsp_both", rv0[k] & rv1[k], 0);
      if (idx < 0) check("rsp_unexpected", 1, 0);
      else begin
        e = sb[idx];
        sb.delete(idx);
        check("rsp_port", rv1[k], e.port);
        check("rsp_rdata", e.port ? rd1[k] : rd0[k], e.rdata);
        check("rsp_cycle", cyc, e.due);
      end
    end
    if (v0[k] || v1[k]) begin
      if (cyc >= free_c[k]) begin
        w = (v0[k] && v1[k]) ? !m_rr[k] : v1[k];
        check("ready0", rdy0[k], v0[k] && !w);
        check("ready1", rdy1[k], v1[k] && w);
        e.inst  = k;
        e.port  = w;
        e.we    = w ? we1[k] : we0[k];
        e.addr  = w ? a1[k] : a0[k];
        e.wdata = w ? d1[k] : d0[k];
        e.rdata = e.we ? 32'h0 : shadow[k][e.addr[7:2]];
        lat     = e.we ? 1 : lat_of(k);
        e.due   = cyc + 1 + lat;
        if (e.we) shadow[k][e.addr[7:2]] = e.wdata;
        sb.push_back(e);
        m_rr[k]   = w;
        acc_c[k]  = cyc;
        free_c[k] = cyc + 2 + lat;
      end else begin
        check("ready0_busy", rdy0[k], 0);
        check("ready1_busy", rdy1[k], 0);
      end
    end
    if (k == 0 && rdy0[k] && v0[k]) glog.push_back(0);
    if (k == 0 && rdy1[k] && v1[k]) glog.push_back(1);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive(input int k, input bit p, input bit we,
                       input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    if (!p) begin
      v0[k] = 1'b1; we0[k] = we; a0[k] = addr; d0[k] = data;
    end else begin
      v1[k] = 1'b1; we1[k] = we; a1[k] = addr; d1[k] = data;
    end
    forever begin
      @(negedge clk);
      if (p ? rdy1[k] : rdy0[k]) break;
      n++;
      if (n > 100) begin
        check("req_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!p) v0[k] = 1'b0;
    else v1[k] = 1'b0;
  endtask

  task automatic do_reset(input int k, input int n);
    rst_n[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n[k] = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      v0[k] = 1'b0; we0[k] = 1'b0; a0[k] = '0; d0[k] = '0;
      v1[k] = 1'b0; we1[k] = 1'b0; a1[k] = '0; d1[k] = '0;
      post_rst[k] = 0;
      acc_c[k] = 0; free_c[k] = 0; rrun[k] = 0; wrun[k] = 0;
      m_rr[k] = 1'b1;
    end
    gap(2);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Write then read back on port 0, single-cycle latency.
    drive(0, 0, 1, 32'd0, 32'd20);
    drive(0, 0, 0, 32'd0, 32'd0);
    gap(4);

    // Simultaneous writes straight after reset: port 0 first.
    do_reset(0, 1);
    fork
      drive(0, 0, 1, 32'd4, 32'hA);
      drive(0, 1, 1, 32'd8, 32'hB);
    join
    drive(0, 1, 0, 32'd8, 32'd0);
    gap(4);

    // Both ports streaming reads: grants must alternate.
    glog.delete();
    fork
      begin
        drive(0, 0, 0, 32'd0, 32'd0);
        drive(0, 0, 0, 32'd4, 32'd0);
        drive(0, 0, 0, 32'd8, 32'd0);
      end
      begin
        drive(0, 1, 0, 32'd4, 32'd0);
        drive(0, 1, 0, 32'd8, 32'd0);
        drive(0, 1, 0, 32'd0, 32'd0);
      end
    join
    gap(4);
    check("grant_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) check("grant_order", glog[i], i % 2);

    // Nothing valid: memory side stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_mem_read", mr[0], 0);
      check("idle_mem_write", mw[0], 0);
      check("idle_busy", bz[0], 0);
    end
    gap(1);

    // Three-cycle latency: port 1 read while port 0 arrives mid-access.
    drive(1, 1, 1, 32'd12, 32'h1234);
    gap(3);
    fork
      drive(1, 1, 0, 32'd12, 32'd0);
      begin
        gap(1);
        drive(1, 0, 0, 32'd12, 32'd0);
      end
    join
    gap(8);

    // Reset while the read sits in WAIT aborts it without a response.
    drive(1, 0, 0, 32'd12, 32'd0);
    gap(1);
    do_reset(1, 1);
    gap(2);
    drive(1, 0, 0, 32'd12, 32'd0);

    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    gap(1);
    check("responses_outstanding", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
